// File: rtl/blink_rate_ctrl_if.sv
// Signal bundle between the board-facing driver and the blink-rate controller.
// The master drives the button and run enable; the slave returns rate, tick and press.
interface blink_rate_ctrl_if;
   logic       KEY;
   logic       run;
   logic       tick;
   logic [1:0] rate_idx;
   logic       press;

   modport master (output KEY, run, input tick, rate_idx, press);
   modport slave  (input KEY, run, output tick, rate_idx, press);
endinterface

// File: rtl/blink_rate_ctrl.sv
// Debounces the active-low KEY into press events that step through four blink rates,
// and emits a one-cycle tick at the selected rate for the downstream LED blinker.
module blink_rate_ctrl #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int DIV0            = 50000000,
   parameter int DIV1            = 25000000,
   parameter int DIV2            = 12500000,
   parameter int DIV3            = 6250000,
   parameter int CNT_W           = 26
) (
   input  logic              CLOCK_50,
   input  logic              RESET,
   blink_rate_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {R0 = 2'd0, R1 = 2'd1, R2 = 2'd2, R3 = 2'd3} rate_e;

   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV0_LAST = CNT_W'(DIV0 - 1);
   localparam logic [CNT_W-1:0] DIV1_LAST = CNT_W'(DIV1 - 1);
   localparam logic [CNT_W-1:0] DIV2_LAST = CNT_W'(DIV2 - 1);
   localparam logic [CNT_W-1:0] DIV3_LAST = CNT_W'(DIV3 - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_deb;
   logic [CNT_W-1:0] r_db_cnt;
   logic             r_press;
   logic             r_tick;
   logic [CNT_W-1:0] r_presc;
   rate_e            r_state;
   rate_e            w_state_next;
   logic             w_accept;
   logic             w_press_set;
   logic [CNT_W-1:0] w_div_last;

   // Accepting a new level and detecting a press share one edge, so press,
   // rate change and prescaler clear all become visible in the same cycle.
   assign w_accept    = (r_sync2 != r_deb) && (r_db_cnt == DB_LAST);
   assign w_press_set = w_accept && !r_sync2;

   // NOTE: sequential state uses <= so every flop samples pre-edge values and
   // the synchronizer chain really is two stages deep.
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         r_sync1  <= 1'b1;
         r_sync2  <= 1'b1;
         r_deb    <= 1'b1;
         r_db_cnt <= '0;
         r_press  <= 1'b0;
      end else begin
         r_sync1 <= bus.KEY;
         r_sync2 <= r_sync1;
         r_press <= w_press_set;
         if (r_sync2 == r_deb) begin
            r_db_cnt <= '0;
         end else if (w_accept) begin
            r_deb    <= r_sync2;
            r_db_cnt <= '0;
         end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (RESET) r_state <= R0;
      else       r_state <= w_state_next;
   end

   // NOTE: the default assignment up front keeps this block purely
   // combinational; a path that skips it would infer a latch.
   always_comb begin
      w_state_next = r_state;
      if (w_press_set) begin
         case (r_state)
            R0:      w_state_next = R1;
            R1:      w_state_next = R2;
            R2:      w_state_next = R3;
            R3:      w_state_next = R0;
            default: w_state_next = R0;
         endcase
      end
   end

   always_comb begin
      w_div_last = DIV0_LAST;
      case (r_state)
         R0:      w_div_last = DIV0_LAST;
         R1:      w_div_last = DIV1_LAST;
         R2:      w_div_last = DIV2_LAST;
         R3:      w_div_last = DIV3_LAST;
         default: w_div_last = DIV0_LAST;
      endcase
   end

   // A press beats terminal count so the new rate always starts a full period.
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         r_presc <= '0;
         r_tick  <= 1'b0;
      end else if (w_press_set) begin
         r_presc <= '0;
         r_tick  <= 1'b0;
      end else if (!bus.run) begin
         r_tick  <= 1'b0;
      end else if (r_presc == w_div_last) begin
         r_presc <= '0;
         r_tick  <= 1'b1;
      end else begin
         r_presc <= r_presc + 1'b1;
         r_tick  <= 1'b0;
      end
   end

   assign bus.tick     = r_tick;
   assign bus.rate_idx = r_state;
   assign bus.press    = r_press;

endmodule

// File: tb/tb_blink_rate_ctrl.sv
// Directed scenarios plus randomized KEY/run/RESET traffic, every cycle compared
// against a rate/period model of the blink-rate controller.
module tb_blink_rate_ctrl;

   localparam int DB = 4;

   logic CLOCK_50;
   logic RESET;
   int   n_checks;
   int   n_errors;

   blink_rate_ctrl_if bus ();

   blink_rate_ctrl #(
      .DEBOUNCE_CYCLES (DB),
      .DIV0            (8),
      .DIV1            (4),
      .DIV2            (2),
      .DIV3            (1),
      .CNT_W           (8)
   ) u_dut (
      .CLOCK_50 (CLOCK_50),
      .RESET    (RESET),
      .bus      (bus)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   // Reference model: key_s is KEY two edges late, a level is accepted after DB
   // consecutive differing samples, rate is presses mod 4, and a tick fires when
   // the run-edges since the last clear reach a multiple of the period.
   int   divs [4] = '{8, 4, 2, 1};
   bit   m_hist [$];
   bit   m_level;
   int   m_streak;
   int   m_presses;
   int   m_elapsed;
   bit   m_tick;
   bit   m_press;

   function automatic void model_edge();
      bit key_s;
      if (RESET) begin
         m_hist    = {1'b1, 1'b1};
         m_level   = 1'b1;
         m_streak  = 0;
         m_presses = 0;
         m_elapsed = 0;
         m_tick    = 1'b0;
         m_press   = 1'b0;
      end else begin
         key_s = m_hist.pop_front();
         m_hist.push_back(bus.KEY);
         m_press = 1'b0;
         if (key_s != m_level) begin
            m_streak++;
            if (m_streak == DB) begin
               m_level  = key_s;
               m_streak = 0;
               m_press  = (key_s == 1'b0);
            end
         end else begin
            m_streak = 0;
         end
         if (m_press) begin
            m_presses++;
            m_elapsed = 0;
            m_tick    = 1'b0;
         end else if (bus.run) begin
            m_elapsed++;
            m_tick = (m_elapsed % divs[m_presses % 4]) == 0;
         end else begin
            m_tick = 1'b0;
         end
      end
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock edge: advance the model on the inputs the DUT sampled, then compare.
   task automatic step();
      @(posedge CLOCK_50);
      model_edge();
      #1;
      check("tick", bus.tick, m_tick);
      check("rate", bus.rate_idx, m_presses % 4);
      check("press", bus.press, m_press);
   endtask

   task automatic wait_tick(output int n);
      n = -1;
      for (int i = 1; i <= 64; i++) begin
         step();
         if (bus.tick === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   // Drops KEY and returns the number of edges until press; KEY stays low.
   task automatic push(output int lat);
      bus.KEY = 1'b0;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (bus.press === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic release_key();
      bus.KEY = 1'b1;
      repeat (10) step();
   endtask

   task automatic wait_phase(input int div, input int phase);
      int k;
      k = 0;
      while ((m_elapsed % div) != phase && k < 40) begin
         step();
         k++;
      end
      check("phase_reached", m_elapsed % div, phase);
   endtask

   initial begin
      int n;
      int n_tick;
      int n_press;
      int lat;
      int exp_rates [4];
      exp_rates = '{1, 2, 3, 0};
      n_checks  = 0;
      n_errors  = 0;

      bus.KEY = 1'b1;
      bus.run = 1'b0;
      RESET   = 1'b1;
      step();
      check("rst_rate", bus.rate_idx, 0);
      check("rst_tick", bus.tick, 0);
      check("rst_press", bus.press, 0);
      RESET = 1'b0;

      // Free-running at rate 0: one tick every 8 cycles.
      bus.run = 1'b1;
      n_tick  = 0;
      n_press = 0;
      repeat (40) begin
         step();
         n_tick  += int'(bus.tick);
         n_press += int'(bus.press);
      end
      check("idle_ticks", n_tick, 5);
      check("idle_press", n_press, 0);

      // Held press: latency DEBOUNCE+2, then period 4 from the cleared prescaler.
      push(lat);
      check("press_latency", lat, 6);
      check("press_rate", bus.rate_idx, 1);
      wait_tick(n);
      check("rate1_first", n, 4);
      wait_tick(n);
      check("rate1_next", n, 4);
      release_key();

      // Short glitch is discarded.
      n_press = 0;
      bus.KEY = 1'b0;
      repeat (3) begin
         step();
         n_press += int'(bus.press);
      end
      bus.KEY = 1'b1;
      repeat (12) begin
         step();
         n_press += int'(bus.press);
      end
      check("glitch_press", n_press, 0);
      check("glitch_rate", bus.rate_idx, 1);
      wait_tick(n);
      wait_tick(n);
      check("glitch_period", n, 4);

      // Four clean presses from rate 0 cycle 1,2,3,0; rate 3 ticks every cycle.
      RESET = 1'b1;
      step();
      RESET = 1'b0;
      for (int p = 0; p < 4; p++) begin
         push(lat);
         check("cycle_latency", lat, 6);
         check("cycle_rate", bus.rate_idx, exp_rates[p]);
         if (p == 2) begin
            n_tick = 0;
            repeat (5) begin
               step();
               n_tick += int'(bus.tick);
            end
            check("rate3_ticks", n_tick, 5);
         end
         release_key();
      end

      // Pause at prescaler 5, resume three edges from the tick.
      wait_phase(8, 5);
      bus.run = 1'b0;
      n_tick  = 0;
      repeat (10) begin
         step();
         n_tick += int'(bus.tick);
      end
      check("paused_ticks", n_tick, 0);
      bus.run = 1'b1;
      wait_tick(n);
      check("resume_tick", n, 3);

      // Press lands on the terminal-count edge of rate 0.
      wait_phase(8, 2);
      bus.KEY = 1'b0;
      repeat (6) step();
      check("tc_press", bus.press, 1);
      check("tc_tick", bus.tick, 0);
      check("tc_rate", bus.rate_idx, 1);
      wait_tick(n);
      check("tc_next_tick", n, 4);
      release_key();

      // Reset mid-count at rate 2.
      push(lat);
      release_key();
      check("pre_rst_rate", bus.rate_idx, 2);
      repeat (1) step();
      RESET = 1'b1;
      step();
      check("midrst_rate", bus.rate_idx, 0);
      check("midrst_tick", bus.tick, 0);
      check("midrst_press", bus.press, 0);
      RESET = 1'b0;
      wait_tick(n);
      check("midrst_first_tick", n, 8);

      // Randomized traffic against the model.
      for (int s = 0; s < 300; s++) begin
         bus.KEY = 1'($urandom_range(0, 1));
         bus.run = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 40) == 0) begin
            RESET = 1'b1;
            step();
            RESET = 1'b0;
         end
         repeat ($urandom_range(1, 12)) step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
